// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared state encoding, region index type and default address map for ROM loading
package rom_load_pkg;
  typedef enum logic [2:0] {EMPTY, LOAD, HOLD, RUN, ERR} state_t;
  typedef logic [1:0] region_t;
  localparam logic [15:0] DEF_R1_BASE = 16'h4000;
  localparam logic [15:0] DEF_R2_BASE = 16'h5000;
  localparam logic [15:0] DEF_R3_BASE = 16'h6000;
  localparam logic [15:0] DEF_LIMIT = 16'h6200;
  localparam logic [15:0] DEF_MIN_BYTES = 16'h6200;
  localparam int DEF_HOLD_CYCLES = 1024;
  function automatic logic [3:0] region_strobe(input region_t r);
    return 4'b0001 << r;
  endfunction
endpackage

// File: rtl/rom_region_dec.sv
// rom_region_dec: maps a download address onto one of four ROM regions, flagging out-of-map addresses
module rom_region_dec
  import rom_load_pkg::*;
#(
  parameter logic [15:0] R1_BASE = DEF_R1_BASE,
  parameter logic [15:0] R2_BASE = DEF_R2_BASE,
  parameter logic [15:0] R3_BASE = DEF_R3_BASE,
  parameter logic [15:0] LIMIT = DEF_LIMIT
) (
  input  logic [24:0] addr,
  output logic        valid,
  output region_t     region
);
  assign valid = addr[24:16] == '0 && addr[15:0] < LIMIT;
  assign region = addr[15:0] < R1_BASE ? 2'd0 :
                  addr[15:0] < R2_BASE ? 2'd1 :
                  addr[15:0] < R3_BASE ? 2'd2 : 2'd3;
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers HPS download bytes into ROM regions and holds the core in reset
// until a complete image has been loaded and allowed to settle.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [15:0] R1_BASE = DEF_R1_BASE,
  parameter logic [15:0] R2_BASE = DEF_R2_BASE,
  parameter logic [15:0] R3_BASE = DEF_R3_BASE,
  parameter logic [15:0] LIMIT = DEF_LIMIT,
  parameter logic [15:0] MIN_BYTES = DEF_MIN_BYTES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        user_reset,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_err,
  output logic        loaded
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic dl_q, dl_rise, dl_fall, addr_ok, ovf_q, ovf_d;
  logic core_reset_q, core_reset_d, load_err_q, load_err_d, loaded_q, loaded_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, rom_addr_q, rom_addr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] rom_we_q, rom_we_d;
  logic [7:0] rom_data_q, rom_data_d;
  region_t region;
  rom_region_dec #(
    .R1_BASE(R1_BASE), .R2_BASE(R2_BASE), .R3_BASE(R3_BASE), .LIMIT(LIMIT)
  ) u_dec (
    .addr(dn_addr), .valid(addr_ok), .region(region)
  );
  assign dl_rise = dn_download & ~dl_q;
  assign dl_fall = ~dn_download & dl_q;
  always_comb begin
    state_d = state_q;
    byte_cnt_d = byte_cnt_q;
    ovf_d = ovf_q;
    hold_d = hold_q;
    rom_we_d = '0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    load_err_d = load_err_q;
    loaded_d = loaded_q;
    if (state_q == LOAD) begin
      if (dn_wr && addr_ok) begin
        rom_we_d = region_strobe(region);
        rom_addr_d = dn_addr[15:0];
        rom_data_d = dn_data;
        byte_cnt_d = byte_cnt_q + 16'(byte_cnt_q != 16'hFFFF);
      end
      if (dn_wr && !addr_ok) ovf_d = 1'b1;
      // a byte arriving with the falling edge is already in byte_cnt_d/ovf_d here
      if (dl_fall) begin
        state_d = (byte_cnt_d >= MIN_BYTES && !ovf_d) ? HOLD : ERR;
        loaded_d = byte_cnt_d >= MIN_BYTES && !ovf_d;
        load_err_d = !(byte_cnt_d >= MIN_BYTES && !ovf_d);
        hold_d = HOLD_INIT;
      end
    end else if (dl_rise) begin
      state_d = LOAD;
      byte_cnt_d = '0;
      ovf_d = 1'b0;
      load_err_d = 1'b0;
      loaded_d = 1'b0;
    end else if (state_q == HOLD) begin
      state_d = hold_q == '0 ? RUN : HOLD;
      hold_d = hold_q - HW'(hold_q != '0);
    end else if (state_q == RUN && user_reset) begin
      state_d = HOLD;
      hold_d = HOLD_INIT;
    end
    core_reset_d = state_q != RUN;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= EMPTY;
      dl_q <= 1'b0;
      byte_cnt_q <= '0;
      ovf_q <= 1'b0;
      hold_q <= '0;
      rom_we_q <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      core_reset_q <= 1'b1;
      load_err_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q <= dn_download;
      byte_cnt_q <= byte_cnt_d;
      ovf_q <= ovf_d;
      hold_q <= hold_d;
      rom_we_q <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      core_reset_q <= core_reset_d;
      load_err_q <= load_err_d;
      loaded_q <= loaded_d;
    end
  end
  assign rom_we = rom_we_q;
  assign rom_addr = rom_addr_q;
  assign rom_data = rom_data_q;
  assign core_reset = core_reset_q;
  assign load_err = load_err_q;
  assign loaded = loaded_q;
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: vector table, directed load sequences and random downloads checked
// against a transaction-level model of the address map and load outcome.
module tb_rom_load_ctrl;
  logic clk_sys, reset, dn_download, dn_wr, user_reset;
  logic [24:0] dn_addr;
  logic [7:0] dn_data;
  logic [3:0] rom_we;
  logic [15:0] rom_addr;
  logic [7:0] rom_data;
  logic core_reset, load_err, loaded;
  int n_chk = 0, n_pass = 0;
  logic [24:0] aq[$];

  typedef struct {
    logic rst, dl, wr, ur;
    logic [24:0] a;
    logic [7:0] d;
    logic [3:0] we;
    logic cr, ld, er;
  } vec_t;
  vec_t tv[17];

  rom_load_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .user_reset(user_reset), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_data(rom_data), .core_reset(core_reset),
    .load_err(load_err), .loaded(loaded)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // model of the address map: expected one-hot strobe, 0 for dropped bytes
  function automatic logic [3:0] exp_we(input logic [24:0] a);
    if (a >= 25'h6200) return 4'd0;
    return a < 25'h4000 ? 4'd1 : a < 25'h5000 ? 4'd2 : a < 25'h6000 ? 4'd4 : 4'd8;
  endfunction

  task automatic do_download(input int gap_max, input bit wr_on_fall);
    int cnt[4] = '{0, 0, 0, 0};
    int exp_cnt[4] = '{0, 0, 0, 0};
    int mism = 0, n_valid = 0, n_bad = 0, k = 0;
    logic [3:0] ew;
    logic [7:0] d;
    bit ok, last;
    dn_download = 1'b1;
    dn_wr = 1'b0;
    step();
    chk("entry_loaded", 32'(loaded), 32'd0);
    chk("entry_load_err", 32'(load_err), 32'd0);
    if (rom_we !== 4'd0) mism++;
    for (int i = 0; i < aq.size(); i++) begin
      last = i == aq.size() - 1;
      d = 8'($urandom);
      dn_wr = 1'b1;
      dn_addr = aq[i];
      dn_data = d;
      if (wr_on_fall && last) dn_download = 1'b0;
      step();
      ew = exp_we(aq[i]);
      if (ew == 4'd0) n_bad++;
      else n_valid++;
      for (int r = 0; r < 4; r++) begin
        if (ew[r]) exp_cnt[r]++;
        if (rom_we[r] === 1'b1) cnt[r]++;
      end
      if (rom_we !== ew || (ew != 4'd0 && (rom_addr !== aq[i][15:0] || rom_data !== d))) mism++;
      dn_wr = 1'b0;
      if (!(wr_on_fall && last))
        repeat ($urandom_range(gap_max, 0)) begin
          step();
          if (rom_we !== 4'd0) mism++;
        end
    end
    if (!wr_on_fall) begin
      dn_download = 1'b0;
      step();
      if (rom_we !== 4'd0) mism++;
    end
    ok = n_valid >= 32'h6200 && n_bad == 0;
    chk("strobe_mismatch_cycles", 32'(mism), 32'd0);
    for (int r = 0; r < 4; r++) chk($sformatf("region%0d_strobes", r), 32'(cnt[r]), 32'(exp_cnt[r]));
    chk("end_loaded", 32'(loaded), 32'(ok));
    chk("end_load_err", 32'(load_err), 32'(!ok));
    chk("end_core_reset", 32'(core_reset), 32'd1);
    if (ok) begin
      while (core_reset === 1'b1 && k < 2000) begin
        step();
        k++;
      end
      chk("release_cycles_after_fall", 32'(k), 32'd1025);
    end
  endtask

  task automatic full_image(input int bad_at);
    aq.delete();
    for (int a = 0; a < 32'h6200; a++) begin
      if (a == bad_at) aq.push_back(25'h6200);
      aq.push_back(25'(a));
    end
  endtask

  initial begin
    int bad, k;
    logic [24:0] a;
    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; user_reset = 1'b0;
    dn_addr = '0; dn_data = '0;
    tv[0]  = '{1, 0, 0, 0, 25'h0,     8'h00, 4'd0, 1, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 25'h0,     8'h00, 4'd0, 1, 0, 0};
    tv[2]  = '{0, 0, 1, 0, 25'h10,    8'h11, 4'd0, 1, 0, 0};
    tv[3]  = '{0, 1, 0, 0, 25'h0,     8'h00, 4'd0, 1, 0, 0};
    tv[4]  = '{0, 1, 1, 0, 25'h0000,  8'hA5, 4'd1, 1, 0, 0};
    tv[5]  = '{0, 1, 1, 0, 25'h3FFF,  8'h01, 4'd1, 1, 0, 0};
    tv[6]  = '{0, 1, 1, 0, 25'h4000,  8'h02, 4'd2, 1, 0, 0};
    tv[7]  = '{0, 1, 1, 0, 25'h4FFF,  8'h03, 4'd2, 1, 0, 0};
    tv[8]  = '{0, 1, 1, 0, 25'h5000,  8'h04, 4'd4, 1, 0, 0};
    tv[9]  = '{0, 1, 1, 0, 25'h5FFF,  8'h05, 4'd4, 1, 0, 0};
    tv[10] = '{0, 1, 1, 0, 25'h6000,  8'h06, 4'd8, 1, 0, 0};
    tv[11] = '{0, 1, 1, 0, 25'h61FF,  8'h07, 4'd8, 1, 0, 0};
    tv[12] = '{0, 1, 1, 0, 25'h6200,  8'h08, 4'd0, 1, 0, 0};
    tv[13] = '{0, 1, 1, 0, 25'h10000, 8'h09, 4'd0, 1, 0, 0};
    tv[14] = '{0, 0, 0, 0, 25'h0,     8'h00, 4'd0, 1, 0, 1};
    tv[15] = '{0, 0, 0, 1, 25'h0,     8'h00, 4'd0, 1, 0, 1};
    tv[16] = '{0, 0, 0, 0, 25'h0,     8'h00, 4'd0, 1, 0, 1};
    for (int i = 0; i < 17; i++) begin
      reset = tv[i].rst; dn_download = tv[i].dl; dn_wr = tv[i].wr; user_reset = tv[i].ur;
      dn_addr = tv[i].a; dn_data = tv[i].d;
      step();
      chk($sformatf("tv%0d_rom_we", i), 32'(rom_we), 32'(tv[i].we));
      chk($sformatf("tv%0d_core_reset", i), 32'(core_reset), 32'(tv[i].cr));
      chk($sformatf("tv%0d_loaded", i), 32'(loaded), 32'(tv[i].ld));
      chk($sformatf("tv%0d_load_err", i), 32'(load_err), 32'(tv[i].er));
      if (tv[i].we != 4'd0) begin
        chk($sformatf("tv%0d_rom_addr", i), 32'(rom_addr), 32'(tv[i].a[15:0]));
        chk($sformatf("tv%0d_rom_data", i), 32'(rom_data), 32'(tv[i].d));
      end
    end
    dn_wr = 1'b0; user_reset = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      step();
      if (core_reset !== 1'b1 || loaded !== 1'b0 || rom_we !== 4'd0) bad++;
    end
    chk("idle_after_reset_bad_cycles", 32'(bad), 32'd0);
    full_image(-1);
    do_download(0, 1'b0);
    user_reset = 1'b1;
    step();
    user_reset = 1'b0;
    step();
    k = 0;
    while (core_reset === 1'b1 && k < 3000) begin
      k++;
      step();
    end
    chk("user_reset_hold_cycles", 32'(k), 32'd1024);
    chk("user_reset_loaded_kept", 32'(loaded), 32'd1);
    user_reset = 1'b1;
    step();
    user_reset = 1'b0;
    repeat (10) step();
    chk("in_hold_core_reset", 32'(core_reset), 32'd1);
    aq = '{25'h100, 25'h4100, 25'h5100, 25'h6100, 25'h6300};
    do_download(1, 1'b0);
    aq.delete();
    for (int i = 0; i < 256; i++) aq.push_back(25'(i));
    do_download(0, 1'b0);
    bad = 0;
    repeat (50) begin
      step();
      if (core_reset !== 1'b1 || load_err !== 1'b1) bad++;
    end
    chk("short_load_stays_err", 32'(bad), 32'd0);
    full_image(-1);
    do_download(0, 1'b1);
    full_image(32'h3000);
    do_download(0, 1'b0);
    dn_download = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      dn_wr = 1'b1; dn_addr = 25'(i); dn_data = 8'(i);
      step();
    end
    reset = 1'b1; dn_download = 1'b0; dn_addr = 25'h20;
    step();
    chk("midload_reset_rom_we", 32'(rom_we), 32'd0);
    chk("midload_reset_core_reset", 32'(core_reset), 32'd1);
    chk("midload_reset_loaded", 32'(loaded), 32'd0);
    reset = 1'b0;
    step();
    chk("empty_ignores_wr", 32'(rom_we), 32'd0);
    dn_wr = 1'b0;
    for (int n = 0; n < 15; n++) begin
      aq.delete();
      for (int i = $urandom_range(200, 1); i > 0; i--) begin
        k = $urandom_range(9, 0);
        a = k < 8 ? 25'($urandom_range(32'h61FF, 0)) :
            k == 8 ? 25'($urandom_range(32'hFFFF, 32'h6200)) :
            {9'($urandom_range(511, 1)), 16'($urandom)};
        aq.push_back(a);
      end
      do_download($urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
